// File: rtl/inst_fetch_unit_if.sv
// Fetch-unit bundle: instruction-memory request/response, core redirect and the decode-side queue head.
interface inst_fetch_unit_if #(
    parameter int XLEN = 64
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [31:0]     imem_rdata;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            inst_valid;
    logic            inst_ready;
    logic [31:0]     inst;
    logic [XLEN-1:0] inst_pc;
    logic            misalign_fault;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        input  redirect, redirect_pc,
        output inst_valid, inst, inst_pc, misalign_fault,
        input  inst_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        output redirect, redirect_pc,
        input  inst_valid, inst, inst_pc, misalign_fault,
        output inst_ready
    );
endinterface

// File: rtl/inst_fetch_unit.sv
// In-order instruction fetch with DEPTH-entry prefetch queue; FETCH_ALIGN_CHECK_EN adds a misaligned-redirect FAULT state.
// Latency: request the cycle after reset/redirect; response to inst_valid is 1 cycle (no bypass).
// Backpressure: requests are credit-limited so queued + outstanding never exceeds DEPTH.
module inst_fetch_unit #(
    parameter int              XLEN     = 64,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input logic               clk,
    input logic               reset,
    inst_fetch_unit_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] CAP = (CW+1)'(DEPTH);

    typedef struct packed {
        logic [31:0]     inst;
        logic [XLEN-1:0] pc;
    } entry_t;

    typedef enum logic {RUN = 1'b0, FAULT = 1'b1} state_t;

    state_t          state, state_nxt;
    entry_t          queue [DEPTH];
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count, outstanding, outstanding_nxt, drop_cnt;
    logic [CW:0]     inflight;
    logic [XLEN-1:0] fetch_pc, resp_pc, target;
    logic            req, accept, drop, push, pop;

    assign target   = {bus.redirect_pc[XLEN-1:2], 2'b00};
    assign inflight = {1'b0, count} + {1'b0, outstanding};
    assign req      = reset && (state == RUN) && !bus.redirect && (inflight < CAP);
    assign accept   = req && bus.imem_gnt;
    // A response landing in the redirect cycle belongs to the old stream.
    assign drop     = bus.imem_rvalid && (bus.redirect || (drop_cnt != '0));
    assign push     = bus.imem_rvalid && !drop;
    assign pop      = (count != '0) && bus.inst_ready && !bus.redirect;
    assign outstanding_nxt = outstanding + CW'(accept) - CW'(bus.imem_rvalid);

`ifdef FETCH_ALIGN_CHECK_EN
    logic misaligned;
    assign misaligned = bus.redirect_pc[1:0] != 2'b00;
`else
    logic unused_low_bits;
    assign unused_low_bits = ^bus.redirect_pc[1:0];
`endif

    always_ff @(posedge clk) begin
        if (!reset) state <= RUN;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
`ifdef FETCH_ALIGN_CHECK_EN
        if (bus.redirect) state_nxt = misaligned ? FAULT : RUN;
`endif
    end

    always_comb begin
        bus.imem_req       = req;
        bus.imem_addr      = fetch_pc;
        bus.inst_valid     = count != '0;
        bus.inst           = queue[rd_ptr].inst;
        bus.inst_pc        = queue[rd_ptr].pc;
        bus.misalign_fault = state == FAULT;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            for (int i = 0; i < DEPTH; i++) queue[i] <= '0;
        end else begin
            outstanding <= outstanding_nxt;
            if (bus.redirect) begin
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                fetch_pc <= target;
                resp_pc  <= target;
                drop_cnt <= outstanding_nxt;
            end else begin
                if (accept) fetch_pc <= fetch_pc + XLEN'(4);
                if (bus.imem_rvalid && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
                if (push) begin
                    queue[wr_ptr] <= '{inst: bus.imem_rdata, pc: resp_pc};
                    wr_ptr        <= wr_ptr + 1'b1;
                    resp_pc       <= resp_pc + XLEN'(4);
                end
                if (pop) rd_ptr <= rd_ptr + 1'b1;
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end
endmodule

// File: tb/tb_inst_fetch_unit.sv
// Randomized bench for inst_fetch_unit: in-order memory model with epoch-tagged requests plus a stream-level reference.
module tb_inst_fetch_unit;
    localparam int          XLEN  = 64;
    localparam int          DEPTH = 4;
    localparam logic [63:0] RPC   = 64'h100;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    inst_fetch_unit_if #(.XLEN(XLEN)) bus ();

    inst_fetch_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic [63:0] addr;
        int          epoch;
        int          due;
    } mreq_t;

    mreq_t       mem_q[$];
    logic [63:0] pop_log[$];
    int          pop_cyc[$];
    int          checks = 0, errors = 0, cyc = 0;
    int          lat = 1, last_due = 0, epoch = 0, buffered = 0, grants = 0;
    bit          rand_lat = 1'b0, fault = 1'b0, last_rv = 1'b0, last_head_rdy = 1'b0;
    logic [63:0] exp_fetch = RPC, exp_pc = RPC;

    function automatic logic [31:0] data_of(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0F0F_1234;
    endfunction

    function automatic bit is_mis(input logic [63:0] p);
`ifdef FETCH_ALIGN_CHECK_EN
        return p[1:0] != 2'b00;
`else
        return (p[1:0] != 2'b00) && 1'b0;
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_pc = '0;
        bus.imem_gnt = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata = '0;
        bus.inst_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
            #1;
            chk("req_in_reset", bus.imem_req, 0);
            @(posedge clk); #1;
            cyc++;
        end
        chk("rst_addr", bus.imem_addr, RPC);
        chk("rst_valid", bus.inst_valid, 0);
        chk("rst_inst", bus.inst, 0);
        chk("rst_inst_pc", bus.inst_pc, 0);
        chk("rst_fault", bus.misalign_fault, 0);
        mem_q.delete();
        buffered = 0;
        epoch++;
        exp_fetch = RPC;
        exp_pc = RPC;
        fault = 1'b0;
        last_due = cyc;
        reset = 1'b1;
    endtask

    // One clock: drive memory/core inputs, compare against the model, advance the model.
    task automatic step(input bit r, input logic [63:0] rpc, input bit g, input bit rdy);
        int pend, rep;
        bit rv, exp_req, acc, pop;
        logic [63:0] tgt;
        pend = mem_q.size();
        rv = 1'b0;
        rep = -1;
        if (pend > 0 && mem_q[0].due <= cyc) begin
            rv = 1'b1;
            rep = mem_q[0].epoch;
            bus.imem_rdata = data_of(mem_q[0].addr);
            void'(mem_q.pop_front());
        end else begin
            bus.imem_rdata = $urandom;
        end
        bus.imem_rvalid = rv;
        bus.redirect = r;
        bus.redirect_pc = rpc;
        bus.imem_gnt = g;
        bus.inst_ready = rdy;
        #1;
        exp_req = !r && !fault && (buffered + pend) < DEPTH;
        chk("imem_req", bus.imem_req, exp_req);
        if (exp_req) chk("imem_addr", bus.imem_addr, exp_fetch);
        chk("inst_valid", bus.inst_valid, buffered != 0);
        if (buffered != 0) begin
            chk("inst_pc", bus.inst_pc, exp_pc);
            chk("inst", bus.inst, data_of(exp_pc));
        end
        chk("misalign_fault", bus.misalign_fault, fault);
        last_rv = rv;
        last_head_rdy = (buffered != 0) && rdy;
        acc = bus.imem_req && g;
        pop = !r && (buffered != 0) && rdy;
        if (pop) begin
            pop_log.push_back(bus.inst_pc);
            pop_cyc.push_back(cyc);
            buffered--;
            exp_pc += 64'd4;
        end
        if (rv && rep == epoch && !r) buffered++;
        if (acc) begin
            int l, d;
            l = rand_lat ? $urandom_range(1, 4) : lat;
            d = cyc + l;
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            mem_q.push_back('{bus.imem_addr, epoch, d});
            exp_fetch += 64'd4;
            grants++;
        end
        if (r) begin
            tgt = {rpc[63:2], 2'b00};
            epoch++;
            buffered = 0;
            exp_pc = tgt;
            exp_fetch = tgt;
            fault = is_mis(rpc);
        end
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic clear_logs();
        pop_log.delete();
        pop_cyc.delete();
        grants = 0;
    endtask

    initial begin
        logic [63:0] rpc;
        do_reset(3);

        // Streaming from RESET_PC: one instruction per cycle, first valid two cycles after the first grant.
        lat = 1;
        clear_logs();
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, 1'b1);
        chk("t1_enough_pops", pop_log.size() >= 3, 1);
        if (pop_log.size() >= 3) begin
            chk("t1_pc0", pop_log[0], 64'h100);
            chk("t1_pc1", pop_log[1], 64'h104);
            chk("t1_pc2", pop_log[2], 64'h108);
            chk("t1_first_cycle", pop_cyc[0], 5);
            chk("t1_b2b_1", pop_cyc[1], pop_cyc[0] + 1);
            chk("t1_b2b_2", pop_cyc[2], pop_cyc[1] + 1);
        end

        // Stalled consumer: exactly DEPTH requests, then drain without loss.
        do_reset(2);
        clear_logs();
        for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1, 1'b0);
        chk("t2_grants", grants, 4);
        chk("t2_valid", bus.inst_valid, 1);
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b0, 1'b1);
        chk("t2_pops", pop_log.size(), 4);
        if (pop_log.size() == 4) chk("t2_last_pc", pop_log[3], 64'h10C);

        // Redirect with two responses in flight at latency 3.
        do_reset(2);
        lat = 3;
        clear_logs();
        step(1'b0, '0, 1'b1, 1'b1);
        step(1'b0, '0, 1'b1, 1'b1);
        chk("t3_grants", grants, 2);
        step(1'b1, 64'h2000, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b1);
        chk("t3_pop_seen", pop_log.size() > 0, 1);
        if (pop_log.size() > 0) chk("t3_first_pc", pop_log[0], 64'h2000);

        // Redirect coinciding with a response and a ready head.
        do_reset(2);
        lat = 1;
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b1);
        step(1'b1, 64'h4000, 1'b1, 1'b1);
        chk("t4_resp_in_cycle", last_rv, 1);
        chk("t4_head_ready", last_head_rdy, 1);
        bus.redirect = 1'b0;
        #1;
        chk("t4_flushed", bus.inst_valid, 0);
        chk("t4_req", bus.imem_req, 1);
        chk("t4_addr", bus.imem_addr, 64'h4000);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b1);

        // Address wrap at the top of the address space.
        clear_logs();
        step(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, 1'b1);
        chk("t5_pops", pop_log.size() >= 2, 1);
        if (pop_log.size() >= 2) begin
            chk("t5_pc0", pop_log[0], 64'hFFFF_FFFF_FFFF_FFFC);
            chk("t5_pc1", pop_log[1], 64'h0);
        end

`ifdef FETCH_ALIGN_CHECK_EN
        step(1'b1, 64'h2002, 1'b1, 1'b1);
        bus.redirect = 1'b0;
        #1;
        chk("t6_fault_set", bus.misalign_fault, 1);
        chk("t6_no_req", bus.imem_req, 0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b1);
        clear_logs();
        step(1'b1, 64'h3000, 1'b1, 1'b1);
        bus.redirect = 1'b0;
        #1;
        chk("t6_fault_clr", bus.misalign_fault, 0);
        chk("t6_req", bus.imem_req, 1);
        chk("t6_addr", bus.imem_addr, 64'h3000);
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, 1'b1);
        if (pop_log.size() > 0) chk("t6_first_pc", pop_log[0], 64'h3000);
        else chk("t6_pop_seen", 0, 1);
`endif

        // Randomized traffic with variable latency, stalls, redirects and one mid-run reset.
        rand_lat = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset(2);
            rpc = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
            step($urandom_range(0, 19) == 0, rpc, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
